// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, fixed WIDTH-cycle latency.
// Responds to a held `div` request with registered s/r and a one-cycle `complete`.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             exception,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             complete,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] rem_r;
    logic [WIDTH-1:0]   abs_y_r;
    logic [WIDTH-1:0]   x_r;
    logic               neg_q_r;
    logic               neg_rem_r;
    logic               y_zero_r;
    logic [WIDTH-1:0]   s_r;
    logic [WIDTH-1:0]   r_r;
    logic               complete_r;
    logic               busy_r;

    logic               x_neg_s;
    logic               y_neg_s;
    logic               carry_s;
    logic [WIDTH-1:0]   hi_s;
    logic [WIDTH-1:0]   diff_s;
    logic               keep_s;
    logic [2*WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0]   s_fin_s;
    logic [WIDTH-1:0]   r_fin_s;

    // Operand sign detection at the accepting edge.
    always_comb begin
        x_neg_s = div_signed & x[WIDTH-1];
        y_neg_s = div_signed & y[WIDTH-1];
    end

    // One restoring step; carry_s is the bit shifted out of the partial remainder,
    // which guarantees the trial subtraction succeeds even when |y| > 2^(WIDTH-1).
    always_comb begin
        carry_s = rem_r[2*WIDTH-1];
        hi_s    = rem_r[2*WIDTH-2:WIDTH-1];
        keep_s  = carry_s | (hi_s >= abs_y_r);
        diff_s  = hi_s - abs_y_r;
        if (keep_s) begin
            rem_next_s = {diff_s, rem_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = {hi_s, rem_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final result: divide-by-zero bypasses sign correction and returns the raw dividend.
    always_comb begin
        if (y_zero_r) begin
            s_fin_s = ALL_ONES;
            r_fin_s = x_r;
        end else begin
            s_fin_s = neg_q_r   ? negate(rem_next_s[WIDTH-1:0])       : rem_next_s[WIDTH-1:0];
            r_fin_s = neg_rem_r ? negate(rem_next_s[2*WIDTH-1:WIDTH]) : rem_next_s[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rem_r      <= {(2*WIDTH){1'b0}};
            abs_y_r    <= ZERO_W;
            x_r        <= ZERO_W;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            y_zero_r   <= 1'b0;
            s_r        <= ZERO_W;
            r_r        <= ZERO_W;
            complete_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    complete_r <= 1'b0;
                    if (div && !exception) begin
                        state_r   <= CALC;
                        busy_r    <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_r     <= {ZERO_W, magnitude(x, div_signed)};
                        abs_y_r   <= magnitude(y, div_signed);
                        x_r       <= x;
                        neg_q_r   <= x_neg_s ^ y_neg_s;
                        neg_rem_r <= x_neg_s;
                        y_zero_r  <= (y == ZERO_W);
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    if (exception) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        rem_r <= rem_next_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == LAST_CNT) begin
                            s_r        <= s_fin_s;
                            r_r        <= r_fin_s;
                            complete_r <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    complete_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    complete_r <= 1'b0;
                end
            endcase
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign complete = complete_r & ~exception;
    assign busy     = busy_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter with hand-computed quotients and remainders.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        div;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        exception;
    logic [31:0] s;
    logic [31:0] r;
    logic        complete;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .div(div), .div_signed(div_signed),
        .x(x), .y(y), .exception(exception),
        .s(s), .r(r), .complete(complete), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation from IDLE; caller is #1 after a rising edge.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic [31:0] er, input string nm);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        div_signed = sg; x = a; y = b; div = 1'b1;
        @(posedge clk); #1;
        if (busy === 1'b1) busy_n++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s accept busy: got %b want 1", nm, busy);
        else pass_cnt++;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) busy_n++;
            if (complete === 1'b1) lat = i;
        end
        total_cnt++;
        if (lat !== 32) $display("FAIL %s latency: got %0d want 32", nm, lat);
        else pass_cnt++;
        total_cnt++;
        if (s !== es) $display("FAIL %s quotient: got %h want %h", nm, s, es);
        else pass_cnt++;
        total_cnt++;
        if (r !== er) $display("FAIL %s remainder: got %h want %h", nm, r, er);
        else pass_cnt++;
        div = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (complete !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after done: got complete=%b busy=%b want 0 0", nm, complete, busy);
        else pass_cnt++;
        total_cnt++;
        if (busy_n !== 33) $display("FAIL %s busy cycles: got %0d want 33", nm, busy_n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        resetn = 1'b0; div = 1'b0; div_signed = 1'b0; x = 32'd0; y = 32'd0; exception = 1'b0;
        #3;
        total_cnt++;
        if (s !== 32'd0 || r !== 32'd0 || complete !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset outputs: got s=%h r=%h c=%b b=%b want all 0", s, r, complete, busy);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset idle busy: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_unsigned();
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "u100_7");
    endtask

    task automatic test_signed();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
        run_op(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         "s_7_m2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, "s_m7_m2");
    endtask

    task automatic test_extremes();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         "s_ovf");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         "u_max_1");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "u_min_max");
    endtask

    task automatic test_div_zero();
        run_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "u_div0");
        run_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "s_div0");
    endtask

    task automatic test_cancel();
        int seen;
        seen = 0;
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "u9_3");
        div_signed = 1'b0; x = 32'd100; y = 32'd7; div = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        exception = 1'b1; div = 1'b0;
        #1;
        total_cnt++;
        if (complete !== 1'b0) $display("FAIL cancel complete: got %b want 0", complete);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL cancel idle: got busy=%b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (s !== 32'd3 || r !== 32'd0)
            $display("FAIL cancel hold: got s=%h r=%h want 3 0", s, r);
        else pass_cnt++;
        exception = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (complete === 1'b1) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL cancel no pulse: got %0d pulses want 0", seen);
        else pass_cnt++;
        run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "u50_5");
    endtask

    task automatic test_idle_exception();
        int acc;
        acc = 0;
        div_signed = 1'b0; x = 32'd77; y = 32'd7; div = 1'b1; exception = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy === 1'b1) acc++;
        end
        total_cnt++;
        if (acc !== 0) $display("FAIL idle exception accept: got %0d busy cycles want 0", acc);
        else pass_cnt++;
        div = 1'b0; exception = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_done_flush();
        div_signed = 1'b0; x = 32'd20; y = 32'd6; div = 1'b1;
        @(posedge clk); #1;
        repeat (32) begin @(posedge clk); #1; end
        total_cnt++;
        if (complete !== 1'b1) $display("FAIL done pulse: got %b want 1", complete);
        else pass_cnt++;
        exception = 1'b1; div = 1'b0;
        #1;
        total_cnt++;
        if (complete !== 1'b0) $display("FAIL done flush gate: got %b want 0", complete);
        else pass_cnt++;
        @(posedge clk); #1;
        exception = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL done flush idle: got busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_held_request();
        int pulses;
        int first;
        int prev;
        int gap_bad;
        int back2back;
        logic last_c;
        pulses = 0; first = -1; prev = -1; gap_bad = 0; back2back = 0; last_c = 1'b0;
        div_signed = 1'b0; x = 32'd9; y = 32'd3; div = 1'b1;
        for (int i = 0; i <= 105; i++) begin
            @(posedge clk); #1;
            if (complete === 1'b1) begin
                if (last_c) back2back++;
                if (first < 0) first = i;
                if (prev >= 0 && (i - prev) != 34) gap_bad++;
                prev = i;
                pulses++;
            end
            last_c = complete;
        end
        total_cnt++;
        if (pulses !== 3) $display("FAIL held pulses: got %0d want 3", pulses);
        else pass_cnt++;
        total_cnt++;
        if (first !== 32) $display("FAIL held first: got %0d want 32", first);
        else pass_cnt++;
        total_cnt++;
        if (gap_bad !== 0 || back2back !== 0)
            $display("FAIL held spacing: got bad_gaps=%0d back_to_back=%0d want 0 0", gap_bad, back2back);
        else pass_cnt++;
    endtask

    // Relies on test_held_request leaving an operation in CALC with s=3.
    task automatic test_reset_mid_calc();
        total_cnt++;
        if (busy !== 1'b1 || s !== 32'd3) $display("FAIL mid precondition: got busy=%b s=%h want 1 3", busy, s);
        else pass_cnt++;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if (s !== 32'd0 || r !== 32'd0 || complete !== 1'b0 || busy !== 1'b0)
            $display("FAIL async reset: got s=%h r=%h c=%b b=%b want all 0", s, r, complete, busy);
        else pass_cnt++;
        div = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL post reset idle: got busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_div_zero();
        test_cancel();
        test_idle_exception();
        test_done_flush();
        test_held_request();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for the execute stage.
- It is the responder to the ALU's DIV/DIVU request: the ALU raises and holds `div` and presents operands; this block returns quotient `s`, remainder `r` and a one-cycle `complete` pulse.
- It supports signed and unsigned division with fixed latency, and can be cancelled by an exception/flush.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- div  input  1  request level, held high by the requester until it sees `complete`.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled at accept.
- x  input  WIDTH  dividend; sampled at accept.
- y  input  WIDTH  divisor; sampled at accept.
- exception  input  1  flush/cancel of the in-flight operation.
- s  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- complete  output  1  result-valid pulse, exactly one cycle.
- busy  output  1  high in CALC and DONE.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, s=0, r=0, complete=0, busy=0, counter=0. Takes effect immediately, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - If div=1 and exception=0 at an edge, that edge is the accepting edge (edge 0). Latch div_signed, x, y, |x| and |y|; go to CALC.
  - If exception=1 in the same cycle, nothing is accepted.
- Magnitudes: when div_signed=1, a negative operand is two's-complement negated. When div_signed=0, operands are used as-is. |0x80000000| = 0x80000000 as an unsigned value.
- CALC:
  - One restoring step per edge, MSB first, over a 2*WIDTH partial-remainder register.
  - Each step: shift left, trial-subtract |y| from the upper WIDTH+1 bits, keep the result if non-negative, shift in the quotient bit.
  - Iterations occur at edges 1..WIDTH. At edge WIDTH, s and r are written with sign correction applied, and state goes to DONE.
- Sign correction (div_signed=1 only):
  - Quotient is negated if x[31]^y[31].
  - Remainder is negated if x[31]; the remainder takes the dividend's sign.
- DONE:
  - complete=1 for exactly this one cycle (after edge WIDTH, before edge WIDTH+1). Return to IDLE at edge WIDTH+1.
  - `div` is ignored in DONE. A request still held high in DONE is not re-accepted until IDLE.
- Latency: complete is high in the cycle following the 32nd edge after the accepting edge (WIDTH=32).
- Divide by zero (latched y=0): full latency, no sign correction. Result is s=all ones, r=latched x.
- Signed overflow (0x80000000 / 0xFFFFFFFF): s=0x80000000, r=0. No flag is raised.
- exception=1 in CALC or DONE:
  - State goes to IDLE at the next edge.
  - complete is forced to 0 combinationally in that cycle, so no pulse is seen.
  - s/r keep their previous values; the partial result is discarded.
- Input changes after accept: changes to x/y/div_signed have no effect until the next accept.
- Outputs s/r: hold their values from the last completed operation until the next completion.

Test Plan:
- Unsigned, x=100, y=7, div_signed=0, div held high → complete exactly 32 edges after the accepting edge, one cycle wide; s=14, r=2; busy high 33 cycles.
- Signed sign cases:
  - x=0xFFFFFFF9 (-7), y=2 → s=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
  - x=7, y=0xFFFFFFFE (-2) → s=0xFFFFFFFD, r=1.
  - x=0xFFFFFFF9, y=0xFFFFFFFE → s=3, r=0xFFFFFFFF.
- Extremes:
  - Signed 0x80000000 / 0xFFFFFFFF → s=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF / 1 → s=0xFFFFFFFF, r=0.
  - Unsigned 0x80000000 / 0xFFFFFFFF → s=0, r=0x80000000.
- Divide by zero: x=0x12345678, y=0, both signs → s=0xFFFFFFFF, r=0x12345678, normal latency.
- Cancel:
  - Sequence: run a 9/3 op to completion, then start 100/7 and assert exception at iteration 10 → no complete pulse; IDLE next edge; s=3, r=0 unchanged.
  - A new 50/5 request then → s=10, r=0 after full latency.
  - exception and div both high in IDLE → not accepted.
- Reset and held request:
  - resetn low mid-CALC → s=r=0, complete=busy=0 immediately, without a clock edge.
  - div held high continuously → one operation per 34 cycles (accept, 32 CALC, DONE); complete never high in two consecutive cycles.
